// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, data-requester and memory-bus signals of the arbiter
interface mem_bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic if_req;
  logic [ADDR_W-1:0] if_addr;
  logic if_done;
  logic [DATA_W-1:0] if_rdata;
  logic if_stall;
  logic dm_req;
  logic dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W/8-1:0] dm_be;
  logic dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic dm_stall;
  logic bus_req;
  logic bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W/8-1:0] bus_be;
  logic bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic bus_err;
  modport master (
    input if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, bus_ack, bus_rdata,
    output if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, bus_ack, bus_rdata,
    input if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
    input bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: IF/DM arbiter for one memory bus; define ARB_TIMEOUT_EN to add the bus watchdog
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.master b
);
  localparam int BE_W = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_DM} state_t;
  state_t state_q, state_d;
  logic last_dm_q, last_dm_d;
  logic bus_req_q, bus_req_d;
  logic bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0] bus_be_q, bus_be_d;
  logic if_done_q, if_done_d;
  logic dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic if_go, dm_go, expire, fin;
  logic [DATA_W-1:0] rdata;
  if (2 ** TO_W <= TIMEOUT) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT");
  end
  // a requester still holding req during its done cycle is not re-granted
  assign if_go = b.if_req & ~if_done_q & ~(b.dm_req & ~dm_done_q & ~last_dm_q);
  assign dm_go = b.dm_req & ~dm_done_q & ~if_go;
  assign fin = b.bus_ack | expire;
  assign rdata = b.bus_ack ? b.bus_rdata : '0;
`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic bus_err_q, bus_err_d;
  assign expire = state_q != IDLE && !b.bus_ack && to_q == TO_W'(TIMEOUT - 1);
  assign to_d = state_q == IDLE ? '0 : to_q + 1'b1;
  assign bus_err_d = bus_err_q | expire;
  always_ff @(posedge clk) begin
    to_q <= rst ? '0 : to_d;
    bus_err_q <= rst ? 1'b0 : bus_err_d;
  end
  assign b.bus_err = bus_err_q;
`else
  assign expire = 1'b0;
  assign b.bus_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_dm_d = last_dm_q;
    bus_req_d = bus_req_q;
    bus_we_d = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d = bus_be_q;
    if_done_d = 1'b0;
    dm_done_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (state_q == IDLE && (if_go || dm_go)) begin
      state_d = dm_go ? BUS_DM : BUS_IF;
      bus_req_d = 1'b1;
      bus_we_d = dm_go & b.dm_we;
      bus_addr_d = dm_go ? b.dm_addr : b.if_addr;
      bus_wdata_d = dm_go ? b.dm_wdata : bus_wdata_q;
      bus_be_d = dm_go && b.dm_we ? b.dm_be : '1;
    end else if (state_q != IDLE && fin) begin
      state_d = IDLE;
      bus_req_d = 1'b0;
      if_done_d = state_q == BUS_IF;
      dm_done_d = state_q == BUS_DM;
      last_dm_d = state_q == BUS_DM;
      if_rdata_d = state_q == BUS_IF ? rdata : if_rdata_q;
      dm_rdata_d = state_q == BUS_DM && !bus_we_q ? rdata : dm_rdata_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_dm_q <= 1'b0;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_addr_q <= '0;
      bus_wdata_q <= '0;
      bus_be_q <= '0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_dm_q <= last_dm_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q <= bus_be_d;
      if_done_q <= if_done_d;
      dm_done_q <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign b.bus_req = bus_req_q;
  assign b.bus_we = bus_we_q;
  assign b.bus_addr = bus_addr_q;
  assign b.bus_wdata = bus_wdata_q;
  assign b.bus_be = bus_be_q;
  assign b.if_done = if_done_q;
  assign b.dm_done = dm_done_q;
  assign b.if_rdata = if_rdata_q;
  assign b.dm_rdata = dm_rdata_q;
  assign b.if_stall = b.if_req & ~if_done_q;
  assign b.dm_stall = b.dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} bus_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .TO_W(3)) dut (.clk(clk), .rst(rst), .b(b));
  int checks = 0;
  int errors = 0;
  bus_t exp_bus_if[$], exp_bus_dm[$];
  logic [31:0] exp_if[$], exp_dm[$];
  int bus_order[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] last_load = 0;
  int min_w = 0, max_w = 3, last_len = 0, n_dm_done = 0, len = 0;
  bit ack_en = 1, force_ack = 0, in_txn = 0, mon_dm;
  bus_t cap, mon_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h40 ? 32'h2402_0005 : {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i+:8] = d[8*i+:8];
    return o;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ram_init(a);
  endfunction
  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (a < 32'h100) return rom(a);
    return dev_mem.exists(a) ? dev_mem[a] : ram_init(a);
  endfunction
  task automatic do_if(input logic [31:0] a);
    bit got;
    exp_bus_if.push_back('{1'b0, a, 32'h0, 4'hf});
    exp_if.push_back(rom(a));
    b.if_req = 1;
    b.if_addr = a;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = b.if_done;
    end
    chk("if_done_timeout", 32'(got), 1);
    @(posedge clk); #1;
    b.if_req = 0;
  endtask
  task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bit got;
    exp_bus_dm.push_back('{we, a, d, we ? be : 4'hf});
    if (we) begin
      exp_dm.push_back(last_load);
      ref_mem[a] = merge(ref_rd(a), d, be);
    end else begin
      last_load = ref_rd(a);
      exp_dm.push_back(last_load);
    end
    b.dm_req = 1;
    b.dm_we = we;
    b.dm_addr = a;
    b.dm_wdata = d;
    b.dm_be = be;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = b.dm_done;
    end
    chk("dm_done_timeout", 32'(got), 1);
    @(posedge clk); #1;
    b.dm_req = 0;
  endtask
  // memory model: random wait states, answers reads from its own array
  initial begin
    int w;
    bit busy;
    busy = 0;
    w = 0;
    b.bus_ack = 0;
    b.bus_rdata = 0;
    forever begin
      @(posedge clk); #2;
      b.bus_ack = force_ack;
      if (rst || !b.bus_req) busy = 0;
      else if (ack_en) begin
        if (!busy) begin
          busy = 1;
          w = $urandom_range(max_w, min_w);
        end
        if (w == 0) begin
          b.bus_ack = 1;
          b.bus_rdata = dev_rd(b.bus_addr);
          if (b.bus_we) dev_mem[b.bus_addr] = merge(b.bus_rdata, b.bus_wdata, b.bus_be);
        end else w--;
      end
    end
  end
  always @(negedge clk) begin
    if (rst || !b.bus_req) in_txn = 0;
    else begin
      if (!in_txn) begin
        in_txn = 1;
        len = 0;
        cap = '{b.bus_we, b.bus_addr, b.bus_wdata, b.bus_be};
      end
      len++;
      chk("bus_addr_stable", b.bus_addr, cap.addr);
      chk("bus_wdata_stable", b.bus_wdata, cap.wdata);
      chk("bus_we_be_stable", {b.bus_we, b.bus_be}, {cap.we, cap.be});
      if (b.bus_ack) begin
        mon_dm = b.bus_addr >= 32'h100;
        bus_order.push_back(int'(mon_dm));
        last_len = len;
        if (mon_dm ? exp_bus_dm.size() == 0 : exp_bus_if.size() == 0) chk("bus_unexpected", 32'(b.bus_req), 0);
        else begin
          if (mon_dm) mon_t = exp_bus_dm.pop_front();
          else mon_t = exp_bus_if.pop_front();
          chk("bus_addr", b.bus_addr, mon_t.addr);
          chk("bus_we", 32'(b.bus_we), 32'(mon_t.we));
          chk("bus_be", 32'(b.bus_be), 32'(mon_t.be));
          if (mon_t.we) chk("bus_wdata", b.bus_wdata, mon_t.wdata);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("if_stall", 32'(b.if_stall), 32'(b.if_req & ~b.if_done));
      chk("dm_stall", 32'(b.dm_stall), 32'(b.dm_req & ~b.dm_done));
      chk("done_overlap", 32'(b.if_done & b.dm_done), 0);
      if (b.if_done) begin
        if (exp_if.size() == 0) chk("if_done_unexpected", 32'(b.if_done), 0);
        else chk("if_rdata", b.if_rdata, exp_if.pop_front());
      end
      if (b.dm_done) begin
        n_dm_done++;
        if (exp_dm.size() == 0) chk("dm_done_unexpected", 32'(b.dm_done), 0);
        else chk("dm_rdata", b.dm_rdata, exp_dm.pop_front());
      end
    end
  end
  initial begin
    int n0;
    bit got;
    b.if_req = 0; b.if_addr = 0;
    b.dm_req = 0; b.dm_we = 0; b.dm_addr = 0; b.dm_wdata = 0; b.dm_be = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_bus_req", 32'(b.bus_req), 0);
    chk("rst_bus_we", 32'(b.bus_we), 0);
    chk("rst_bus_addr", b.bus_addr, 0);
    chk("rst_bus_wdata", b.bus_wdata, 0);
    chk("rst_bus_be", 32'(b.bus_be), 0);
    chk("rst_done", 32'({b.if_done, b.dm_done}), 0);
    chk("rst_if_rdata", b.if_rdata, 0);
    chk("rst_dm_rdata", b.dm_rdata, 0);
    chk("rst_bus_err", 32'(b.bus_err), 0);
    @(posedge clk); #1;
    min_w = 0; max_w = 0;
    exp_bus_if.push_back('{1'b0, 32'h40, 32'h0, 4'hf});
    exp_if.push_back(rom(32'h40));
    b.if_req = 1;
    b.if_addr = 32'h40;
    @(negedge clk); chk("t1_c1_bus_req", 32'(b.bus_req), 0);
    @(negedge clk); chk("t1_c2_bus_req", 32'(b.bus_req), 1); chk("t1_bus_addr", b.bus_addr, 32'h40);
    @(negedge clk); chk("t1_c3_if_done", 32'(b.if_done), 1);
    @(posedge clk); #1;
    b.if_req = 0;
    min_w = 0; max_w = 2;
    bus_order.delete();
    fork
      do_if(32'h10);
      do_dm(1'b0, 32'h104, 32'h0, 4'h0);
    join
    chk("t2a_count", bus_order.size(), 2);
    if (bus_order.size() == 2) begin
      chk("t2a_first_dm", bus_order[0], 1);
      chk("t2a_second_if", bus_order[1], 0);
    end
    do_dm(1'b1, 32'h108, 32'hCAFE_F00D, 4'hf);
    bus_order.delete();
    fork
      do_if(32'h14);
      do_dm(1'b0, 32'h108, 32'h0, 4'h0);
    join
    chk("t2b_count", bus_order.size(), 2);
    if (bus_order.size() == 2) begin
      chk("t2b_first_if", bus_order[0], 0);
      chk("t2b_second_dm", bus_order[1], 1);
    end
    min_w = 3; max_w = 3;
    do_dm(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    chk("t3_bus_cycles", last_len, 4);
    min_w = 0; max_w = 3;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_if(32'($urandom_range(0, 63) * 4));
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_dm(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(1, 15)));
      end
    join
    ack_en = 0;
    b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h1F0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = b.bus_req;
    end
    chk("t4_bus_req_up", 32'(b.bus_req), 1);
    @(posedge clk); #1;
    rst = 1;
    b.dm_req = 0;
    @(posedge clk); #1;
    rst = 0;
    last_load = 0;
    @(negedge clk); chk("t4_bus_req_rst", 32'(b.bus_req), 0);
    @(posedge clk); #1;
    force_ack = 1;
    @(posedge clk); #1;
    force_ack = 0;
    @(negedge clk);
    chk("t4_no_dm_done", 32'(b.dm_done), 0);
    chk("t4_bus_req_idle", 32'(b.bus_req), 0);
    ack_en = 1;
    @(posedge clk); #1;
    do_if(32'h20);
`ifdef ARB_TIMEOUT_EN
    ack_en = 0;
    exp_dm.push_back(32'h0);
    b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h180;
    n0 = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b.bus_req || b.dm_done) n0++;
      got = b.dm_done;
    end
    chk("t5_done_cycle", n0, 5);
    chk("t5_bus_err_set", 32'(b.bus_err), 1);
    @(posedge clk); #1;
    b.dm_req = 0;
    repeat (3) @(negedge clk);
    chk("t5_bus_err_sticky", 32'(b.bus_err), 1);
    chk("t5_bus_req_low", 32'(b.bus_req), 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk("t5_bus_err_rst", 32'(b.bus_err), 0);
    ack_en = 1;
`else
    ack_en = 0;
    n0 = n_dm_done;
    fork
      do_dm(1'b0, 32'h180, 32'h0, 4'h0);
      begin
        repeat (20) @(negedge clk);
        chk("t5_bus_req_held", 32'(b.bus_req), 1);
        chk("t5_no_done", n_dm_done, n0);
        chk("t5_bus_err_zero", 32'(b.bus_err), 0);
        ack_en = 1;
      end
    join
`endif
    repeat (3) @(negedge clk);
    chk("end_exp_if", exp_if.size(), 0);
    chk("end_exp_dm", exp_dm.size(), 0);
    chk("end_exp_bus_if", exp_bus_if.size(), 0);
    chk("end_exp_bus_dm", exp_bus_dm.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
